// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data port (D) over instruction port (I), with a starvation counter.
// Optional sub-word store merging via read-modify-write when MEM_ARB_BYTE_WRITE_EN is defined.
module mem_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
`ifdef MEM_ARB_BYTE_WRITE_EN
  input  logic [3:0]        d_be,
`endif
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic              d_read;
  logic              i_win;
  logic [DATA_W-1:0] merged;

  // I only wins against a pending D request once it has been refused long enough.
  assign i_win = i_req && (!d_req || (starve_cnt >= 4'(STARVE_LIMIT)));

`ifdef MEM_ARB_BYTE_WRITE_EN
  always_comb begin
    merged = ram_q;
    for (int b = 0; b < 4; b++) begin
      if (d_be[b]) merged[8*b +: 8] = d_wdata[8*b +: 8];
    end
  end
`else
  assign merged = d_wdata;
`endif

  always_comb begin
    state_next  = state;
    i_ack       = 1'b0;
    d_ack       = 1'b0;
    d_read      = 1'b0;
    ram_wren    = 1'b0;
    ram_address = addr_q;
    ram_data    = d_wdata;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (i_win) begin
            ram_address = i_addr;
            i_ack       = 1'b1;
          end else if (d_req) begin
            ram_address = d_addr;
            if (!d_we) begin
              d_ack  = 1'b1;
              d_read = 1'b1;
            end else begin
`ifdef MEM_ARB_BYTE_WRITE_EN
              if (d_be == 4'hF) begin
                ram_wren = 1'b1;
                d_ack    = 1'b1;
              end else if (d_be == 4'h0) begin
                d_ack = 1'b1;
              end else begin
                // Fetch the old word now; the merged store happens next cycle.
                state_next = RMW;
              end
`else
              ram_wren = 1'b1;
              d_ack    = 1'b1;
`endif
            end
          end
        end
        RMW: begin
          ram_address = d_addr;
          if (d_req) begin
            ram_wren = 1'b1;
            ram_data = merged;
            d_ack    = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      addr_q     <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state      <= state_next;
      addr_q     <= ram_address;
      i_rvalid_q <= i_ack;
      d_rvalid_q <= d_read;
      if (i_req && !i_ack) begin
        if (starve_cnt != 4'd15) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  assign i_rvalid = i_rvalid_q && !rst;
  assign d_rvalid = d_rvalid_q && !rst;
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a small behavioural RAM (registered read address).
// Byte-write sequences run only when MEM_ARB_BYTE_WRITE_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_ack;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
`ifdef MEM_ARB_BYTE_WRITE_EN
  logic [3:0]  d_be;
`endif
  logic        d_ack;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_wren;
  logic [29:0] ram_address;
  logic [31:0] ram_data;
  logic [31:0] ram_q;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        i_req;
    logic [29:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_i_ack;
    logic        e_d_ack;
    logic        e_wren;
    logic [29:0] e_addr;
    logic        e_i_rvalid;
    logic        e_d_rvalid;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [13];

  mem_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ack(i_ack),
    .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
`ifdef MEM_ARB_BYTE_WRITE_EN
    .d_be(d_be),
`endif
    .d_ack(d_ack),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .ram_wren(ram_wren),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_q(ram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM: write and registered read address on the same edge; write lands before the next read.
  initial begin
    for (int k = 0; k < 64; k++) mem[k] <= 32'hA000_0000 + 32'(k);
  end

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[5:0]] <= ram_data;
    ram_q <= mem[ram_address[5:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ir, input logic [29:0] ia,
                               input logic dr, input logic dw, input logic [29:0] da,
                               input logic [31:0] wd);
    @(negedge clk);
    rst     = r;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = wd;
    #1;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b1; i_addr = '0; d_req = 1'b1; d_we = 1'b0; d_addr = 30'd8; d_wdata = '0;
`ifdef MEM_ARB_BYTE_WRITE_EN
    d_be = 4'hF;
`endif

    //              ireq iaddr   dreq we daddr   wdata          iack dack wren addr   irv drv rdata
    vecs[0]  = '{1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0,        1'b0, 1'b1, 1'b0, 30'd8, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0,        1'b0, 1'b1, 1'b0, 30'd8, 1'b0, 1'b1, 32'hA000_0008};
    vecs[2]  = '{1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0,        1'b0, 1'b1, 1'b0, 30'd8, 1'b0, 1'b1, 32'hA000_0008};
    vecs[3]  = '{1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0,        1'b0, 1'b1, 1'b0, 30'd8, 1'b0, 1'b1, 32'hA000_0008};
    vecs[4]  = '{1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0,        1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 1'b1, 32'hA000_0008};
    vecs[5]  = '{1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0,        1'b0, 1'b1, 1'b0, 30'd8, 1'b1, 1'b0, 32'hA000_0000};
    vecs[6]  = '{1'b1, 30'd0, 1'b0, 1'b0, 30'd8, 32'h0,        1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 1'b1, 32'hA000_0008};
    vecs[7]  = '{1'b0, 30'd0, 1'b0, 1'b0, 30'd9, 32'h0,        1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 32'hA000_0000};
    vecs[8]  = '{1'b0, 30'd0, 1'b1, 1'b1, 30'd5, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 30'd5, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 30'd5, 1'b0, 1'b0, 30'd5, 32'h0,        1'b1, 1'b0, 1'b0, 30'd5, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 30'd5, 1'b0, 1'b0, 30'd7, 32'h0,        1'b0, 1'b0, 1'b0, 30'd5, 1'b1, 1'b0, 32'h1111_1111};
    vecs[11] = '{1'b1, 30'd1, 1'b1, 1'b0, 30'd3, 32'h0,        1'b0, 1'b1, 1'b0, 30'd3, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 30'd1, 1'b0, 1'b0, 30'd4, 32'h0,        1'b0, 1'b0, 1'b0, 30'd3, 1'b0, 1'b1, 32'hA000_0003};

    // Reset with both requests pending: everything quiet.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b1, 30'd0, 1'b1, 1'b0, 30'd8, 32'h0);
      checkOutput("rst_i_ack",    32'(i_ack),    32'h0);
      checkOutput("rst_d_ack",    32'(d_ack),    32'h0);
      checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'h0);
      checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'h0);
      checkOutput("rst_ram_wren", 32'(ram_wren), 32'h0);
    end

    for (int v = 0; v < 13; v++) begin
      applyStimulus(1'b0, vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req, vecs[v].d_we,
                    vecs[v].d_addr, vecs[v].d_wdata);
      checkOutput($sformatf("v%0d_i_ack", v),    32'(i_ack),       32'(vecs[v].e_i_ack));
      checkOutput($sformatf("v%0d_d_ack", v),    32'(d_ack),       32'(vecs[v].e_d_ack));
      checkOutput($sformatf("v%0d_wren", v),     32'(ram_wren),    32'(vecs[v].e_wren));
      checkOutput($sformatf("v%0d_address", v),  32'(ram_address), 32'(vecs[v].e_addr));
      checkOutput($sformatf("v%0d_i_rvalid", v), 32'(i_rvalid),    32'(vecs[v].e_i_rvalid));
      checkOutput($sformatf("v%0d_d_rvalid", v), 32'(d_rvalid),    32'(vecs[v].e_d_rvalid));
      if (vecs[v].e_wren)     checkOutput($sformatf("v%0d_ram_data", v), ram_data, vecs[v].d_wdata);
      if (vecs[v].e_i_rvalid) checkOutput($sformatf("v%0d_i_rdata", v),  i_rdata,  vecs[v].e_rdata);
      if (vecs[v].e_d_rvalid) checkOutput($sformatf("v%0d_d_rdata", v),  d_rdata,  vecs[v].e_rdata);
    end

`ifdef MEM_ARB_BYTE_WRITE_EN
    // Seed word 2, then merge byte 1 through the read-modify-write path.
    d_be = 4'hF;
    applyStimulus(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 30'd2, 32'hAABB_CCDD);
    checkOutput("seed_d_ack", 32'(d_ack),    32'h1);
    checkOutput("seed_wren",  32'(ram_wren), 32'h1);
    d_be = 4'b0010;
    applyStimulus(1'b0, 1'b1, 30'd0, 1'b1, 1'b1, 30'd2, 32'h0000_1200);
    checkOutput("rmw1_d_ack", 32'(d_ack),       32'h0);
    checkOutput("rmw1_i_ack", 32'(i_ack),       32'h0);
    checkOutput("rmw1_wren",  32'(ram_wren),    32'h0);
    checkOutput("rmw1_addr",  32'(ram_address), 32'h2);
    applyStimulus(1'b0, 1'b1, 30'd0, 1'b1, 1'b1, 30'd2, 32'h0000_1200);
    checkOutput("rmw2_d_ack", 32'(d_ack),    32'h1);
    checkOutput("rmw2_i_ack", 32'(i_ack),    32'h0);
    checkOutput("rmw2_wren",  32'(ram_wren), 32'h1);
    checkOutput("rmw2_data",  ram_data,      32'hAABB_12DD);
    d_be = 4'h0;
    applyStimulus(1'b0, 1'b1, 30'd0, 1'b1, 1'b1, 30'd2, 32'hFFFF_FFFF);
    checkOutput("be0_d_ack", 32'(d_ack),    32'h1);
    checkOutput("be0_wren",  32'(ram_wren), 32'h0);
    applyStimulus(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 30'd2, 32'h0);
    checkOutput("rb_d_ack", 32'(d_ack), 32'h1);
    applyStimulus(1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
    checkOutput("rb_d_rvalid", 32'(d_rvalid), 32'h1);
    checkOutput("rb_d_rdata",  d_rdata,       32'hAABB_12DD);

    // Reset in the middle of a merge must drop the store entirely.
    d_be = 4'b0001;
    applyStimulus(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 30'd2, 32'h0000_00EE);
    checkOutput("abort1_d_ack", 32'(d_ack), 32'h0);
    applyStimulus(1'b1, 1'b0, 30'd0, 1'b1, 1'b1, 30'd2, 32'h0000_00EE);
    checkOutput("abort2_wren",  32'(ram_wren), 32'h0);
    checkOutput("abort2_d_ack", 32'(d_ack),    32'h0);
    applyStimulus(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 30'd2, 32'h0);
    checkOutput("abort3_d_ack", 32'(d_ack),    32'h1);
    checkOutput("abort3_wren",  32'(ram_wren), 32'h0);
    applyStimulus(1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
    checkOutput("abort4_d_rdata", d_rdata, 32'hAABB_12DD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
